// File: rtl/z80_bus_master.sv
// z80_bus_master: initiator side of the Z80 memory bus.
// Accepts one core request at a time (opcode fetch, memory read or memory
// write) and sequences it into T-states (one clock each) on the active-low
// MREQ_/RD_/WR_/M1_/RFSH_ strobes. Returns read data or a write acknowledge,
// runs the refresh phase of M1 cycles and maintains the 7-bit R counter.
//
// Ports
//   clock, reset          : clock (one clock = one T-state), async active-low reset
//   io_req_*              : core request (valid/ready handshake, kind, addr, wdata)
//   io_rsp_valid/rdata    : one-cycle response pulse, captured read data
//   io_ireg               : I register, upper byte of the refresh address
//   io_r_load/io_r_val    : R register load (LD R,A); io_r is current R
//   io_bus_*              : memory bus; io_bus_rdata is combinational memory data,
//                           io_bus_WAIT_ stretches T2 with wait states
`timescale 1ns/1ps
module z80_bus_master #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_write,
  input  logic              io_req_m1,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [DATA_W-1:0] io_req_wdata,
  output logic              io_rsp_valid,
  output logic [DATA_W-1:0] io_rsp_rdata,
  input  logic [7:0]        io_ireg,
  input  logic              io_r_load,
  input  logic [7:0]        io_r_val,
  output logic [7:0]        io_r,
  output logic [ADDR_W-1:0] io_bus_addr,
  output logic [DATA_W-1:0] io_bus_wdata,
  input  logic [DATA_W-1:0] io_bus_rdata,
  output logic              io_bus_MREQ_,
  output logic              io_bus_RD_,
  output logic              io_bus_WR_,
  output logic              io_bus_M1_,
  output logic              io_bus_RFSH_,
  input  logic              io_bus_WAIT_
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    K_RD = 2'd0,
    K_WR = 2'd1,
    K_M1 = 2'd2
  } kind_e;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic              accept;

  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              mreq_n_q, mreq_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              m1_n_q, m1_n_d;
  logic              rfsh_n_q, rfsh_n_d;
  logic [7:0]        r_q, r_d;

  // State and all output registers; reset aborts any cycle in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      kind_q      <= K_RD;
      ready_q     <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      mreq_n_q    <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      m1_n_q      <= 1'b1;
      rfsh_n_q    <= 1'b1;
      r_q         <= 8'h00;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      mreq_n_q    <= mreq_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      m1_n_q      <= m1_n_d;
      rfsh_n_q    <= rfsh_n_d;
      r_q         <= r_d;
    end
  end

  // Next-state logic; WAIT_ is only sampled at the end of T2/TW.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io_req_valid) begin
          accept  = 1'b1;
          state_d = S_T1;
          if (io_req_write)   kind_d = K_WR;
          else if (io_req_m1) kind_d = K_M1;
          else                kind_d = K_RD;
        end
      end
      S_T1:       state_d = S_T2;
      S_T2, S_TW: state_d = io_bus_WAIT_ ? S_T3 : S_TW;
      S_T3:       state_d = (kind_q == K_M1) ? S_T4 : S_IDLE;
      S_T4:       state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic: values are computed for the state being entered so the
  // registered strobes line up with the T-state they belong to.
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    mreq_n_d    = 1'b1;
    rd_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    m1_n_d      = 1'b1;
    rfsh_n_d    = 1'b1;
    r_d         = r_q;

    if (accept) begin
      addr_d = io_req_addr;
      if (io_req_write) wdata_d = io_req_wdata;
    end

    case (state_d)
      S_T1: begin
        // WR_ stays high in T1 so write data is settled before the strobe.
        mreq_n_d = 1'b0;
        rd_n_d   = (kind_d == K_WR);
        m1_n_d   = (kind_d != K_M1);
      end
      S_T2, S_TW: begin
        mreq_n_d = 1'b0;
        rd_n_d   = (kind_d == K_WR);
        wr_n_d   = (kind_d != K_WR);
        m1_n_d   = (kind_d != K_M1);
      end
      S_T3: begin
        mreq_n_d = 1'b0;
        if (kind_d == K_M1) begin
          // Refresh phase: T3 is only entered from T2/TW, so load {I,R} once.
          rfsh_n_d = 1'b0;
          addr_d   = ADDR_W'({io_ireg, r_q});
        end else begin
          rd_n_d = (kind_d == K_WR);
          wr_n_d = (kind_d != K_WR);
        end
      end
      S_T4: begin
        mreq_n_d = 1'b0;
        rfsh_n_d = 1'b0;
      end
      default: ;
    endcase

    // Read/write complete at the end of T3; fetch data is taken as T3 begins.
    if (state_q == S_T3 && kind_q != K_M1) begin
      rsp_valid_d = 1'b1;
      if (kind_q == K_RD) rdata_d = io_bus_rdata;
    end
    if (kind_q == K_M1 && state_d == S_T3 &&
        (state_q == S_T2 || state_q == S_TW)) begin
      rsp_valid_d = 1'b1;
      rdata_d     = io_bus_rdata;
    end

    // R: low seven bits count fetches, bit 7 only changes via an explicit load.
    if (state_q == S_T4) r_d = {r_q[7], r_q[6:0] + 7'd1};
    if (io_r_load)       r_d = io_r_val;
  end

  assign io_req_ready = ready_q;
  assign io_rsp_valid = rsp_valid_q;
  assign io_rsp_rdata = rdata_q;
  assign io_r         = r_q;
  assign io_bus_addr  = addr_q;
  assign io_bus_wdata = wdata_q;
  assign io_bus_MREQ_ = mreq_n_q;
  assign io_bus_RD_   = rd_n_q;
  assign io_bus_WR_   = wr_n_q;
  assign io_bus_M1_   = m1_n_q;
  assign io_bus_RFSH_ = rfsh_n_q;

endmodule
